// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared definitions for the cache/memory path: default line and beat
//   geometry, the burst-adaptor state encoding and the beat-index type.
package cache_pkg;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_BEAT_W = 64;
  localparam int DEF_BEATS  = DEF_LINE_W / DEF_BEAT_W;
  localparam int DEF_ADDR_W = 32;
  localparam int BEAT_IDX_W = $clog2(DEF_BEATS);

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//   Answers the data cache's line-wide physical-memory port by running a
//   BEATS-long burst on the narrower main-memory bus, then returning a single
//   pmem_resp pulse once the whole line has moved.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for pmem_read / pmem_write (write has priority)
//   RD_BURST | collecting read beats into the line buffer
//   WR_BURST | presenting buffered write beats, one per burst_resp
//   DONE     | one-cycle pmem_resp; always returns to IDLE
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   pmem_read / pmem_write     line requests from cache (level, held to resp)
//   pmem_address               line address from cache
//   pmem_wdata256              line to write back
//   pmem_rdata256              line buffer, driven while pmem_resp=1
//   pmem_resp                  one-cycle completion pulse
//   burst_read / burst_write   memory-side requests
//   burst_address              latched, line-aligned address
//   burst_wdata                current write beat
//   burst_rdata, burst_resp    returned beat and per-beat handshake
module line_burst_adaptor
  import cache_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BEATS  = DEF_BEATS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata256,
  output logic [LINE_W-1:0] pmem_rdata256,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [ADDR_W-1:0] burst_address,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Byte-offset bits within a line; cleared when the address is latched.
  localparam logic [ADDR_W-1:0] LINE_OFFS_MASK = ADDR_W'((LINE_W / 8) - 1);

  burst_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] line_buf;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_write) begin
            line_buf <= pmem_wdata256;
            addr_q   <= pmem_address & ~LINE_OFFS_MASK;
            cnt      <= '0;
            state    <= WR_BURST;
          end else if (pmem_read) begin
            addr_q   <= pmem_address & ~LINE_OFFS_MASK;
            cnt      <= '0;
            state    <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (burst_resp) begin
            line_buf[BEAT_W*cnt +: BEAT_W] <= burst_rdata;
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (burst_resp) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // The cache drops its request during this cycle, so IDLE never
          // resamples a request that has already been served.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All memory/cache-facing outputs come straight from registers; nothing
  // on the pmem_* inputs reaches burst_* combinationally.
  assign burst_read    = (state == RD_BURST);
  assign burst_write   = (state == WR_BURST);
  assign pmem_resp     = (state == DONE);
  assign burst_address = addr_q;
  assign burst_wdata   = burst_write ? line_buf[BEAT_W*cnt +: BEAT_W] : '0;
  assign pmem_rdata256 = pmem_resp ? line_buf : '0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata256;
  logic [255:0] pmem_rdata256;
  logic         pmem_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int resp_cnt = 0;
  int resp_mark;

  line_burst_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata256(pmem_wdata256),
    .pmem_rdata256(pmem_rdata256),
    .pmem_resp    (pmem_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  always #5 clk = ~clk;

  // Counts every cycle in which pmem_resp is high.
  always @(negedge clk) if (pmem_resp === 1'b1) resp_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [63:0] b3, input logic [63:0] b2,
                                           input logic [63:0] b1, input logic [63:0] b0);
    return {b3, b2, b1, b0};
  endfunction

  logic [63:0]  beats [4];
  logic [255:0] wline;

  initial begin
    rst_n = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata256 = '0;
    burst_rdata = '0;
    burst_resp = 1'b0;
    tick();
    tick();
    check("rst_resp",  256'(pmem_resp), 256'(0));
    check("rst_bread", 256'(burst_read), 256'(0));
    check("rst_bwrite", 256'(burst_write), 256'(0));
    check("rst_baddr", 256'(burst_address), 256'(0));
    check("rst_bwdata", 256'(burst_wdata), 256'(0));
    check("rst_rdata", pmem_rdata256, 256'(0));
    rst_n = 1'b1;
    tick();

    // ---- read, zero wait ----
    pmem_read = 1'b1;
    pmem_address = 32'h0000_1234;
    tick();
    check("rd_baddr", 256'(burst_address), 256'(32'h0000_1220));
    check("rd_bwrite0", 256'(burst_write), 256'(0));
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      burst_rdata = beats[i];
      check("rd_bread_hi", 256'(burst_read), 256'(1));
      check("rd_resp_lo", 256'(pmem_resp), 256'(0));
      tick();
    end
    burst_resp = 1'b0;
    burst_rdata = '0;
    check("rd_resp", 256'(pmem_resp), 256'(1));
    check("rd_line", pmem_rdata256, mk_line(beats[3], beats[2], beats[1], beats[0]));
    check("rd_bread_done", 256'(burst_read), 256'(0));
    pmem_read = 1'b0;
    tick();
    check("rd_resp_pulse", 256'(pmem_resp), 256'(0));

    // ---- write, 2-cycle gaps ----
    beats[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    beats[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    beats[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    beats[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    wline = mk_line(beats[3], beats[2], beats[1], beats[0]);
    pmem_write = 1'b1;
    pmem_address = 32'h0000_2000;
    pmem_wdata256 = wline;
    tick();
    check("wr_baddr", 256'(burst_address), 256'(32'h0000_2000));
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        check("wr_bwrite_gap", 256'(burst_write), 256'(1));
        check("wr_wdata_gap", 256'(burst_wdata), 256'(beats[i]));
        check("wr_resp_lo", 256'(pmem_resp), 256'(0));
        tick();
      end
      burst_resp = 1'b1;
      check("wr_wdata_beat", 256'(burst_wdata), 256'(beats[i]));
      tick();
      burst_resp = 1'b0;
    end
    check("wr_resp", 256'(pmem_resp), 256'(1));
    check("wr_line", pmem_rdata256, wline);
    check("wr_bwrite_done", 256'(burst_write), 256'(0));
    pmem_write = 1'b0;
    tick();
    check("wr_resp_pulse", 256'(pmem_resp), 256'(0));

    // ---- writeback then fill ----
    resp_mark = resp_cnt;
    beats[0] = 64'h0123_4567_89AB_CDEF;
    beats[1] = 64'h1000_0000_0000_0001;
    beats[2] = 64'h2000_0000_0000_0002;
    beats[3] = 64'h3000_0000_0000_0003;
    wline = mk_line(beats[3], beats[2], beats[1], beats[0]);
    pmem_write = 1'b1;
    pmem_address = 32'h0000_3040;
    pmem_wdata256 = wline;
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      check("wbf_wdata", 256'(burst_wdata), 256'(beats[i]));
      check("wbf_bread_lo", 256'(burst_read), 256'(0));
      tick();
    end
    burst_resp = 1'b0;
    check("wbf_resp1", 256'(pmem_resp), 256'(1));
    check("wbf_line1", pmem_rdata256, wline);
    pmem_write = 1'b0;
    tick();
    pmem_read = 1'b1;
    pmem_address = 32'h0000_4000;
    tick();
    check("wbf_bread", 256'(burst_read), 256'(1));
    check("wbf_bwrite_lo", 256'(burst_write), 256'(0));
    check("wbf_baddr", 256'(burst_address), 256'(32'h0000_4000));
    beats[0] = 64'h5555_5555_5555_5555;
    beats[1] = 64'h6666_6666_6666_6666;
    beats[2] = 64'h7777_7777_7777_7777;
    beats[3] = 64'h8888_8888_8888_8888;
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      burst_rdata = beats[i];
      tick();
    end
    burst_resp = 1'b0;
    check("wbf_resp2", 256'(pmem_resp), 256'(1));
    check("wbf_line2", pmem_rdata256, mk_line(beats[3], beats[2], beats[1], beats[0]));
    pmem_read = 1'b0;
    tick();
    tick();
    check("wbf_resp_count", 256'(resp_cnt - resp_mark), 256'(2));

    // ---- simultaneous read and write: write wins ----
    wline = {4{64'hF00D_0000_BEEF_0000}};
    pmem_read = 1'b1;
    pmem_write = 1'b1;
    pmem_address = 32'h0000_5000;
    pmem_wdata256 = wline;
    tick();
    check("both_bwrite", 256'(burst_write), 256'(1));
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      check("both_bread_lo", 256'(burst_read), 256'(0));
      tick();
    end
    burst_resp = 1'b0;
    check("both_resp", 256'(pmem_resp), 256'(1));
    check("both_line", pmem_rdata256, wline);
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    tick();

    // ---- reset after beat 2 of a read ----
    pmem_read = 1'b1;
    pmem_address = 32'h0000_6000;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp = 1'b1;
      burst_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
      tick();
    end
    burst_resp = 1'b0;
    check("mid_bread_hi", 256'(burst_read), 256'(1));
    resp_mark = resp_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_bread", 256'(burst_read), 256'(0));
    check("arst_baddr", 256'(burst_address), 256'(0));
    check("arst_resp", 256'(pmem_resp), 256'(0));
    pmem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_no_resp", 256'(resp_cnt - resp_mark), 256'(0));
    beats[0] = 64'h9999_9999_9999_9999;
    beats[1] = 64'hAAAA_0000_0000_AAAA;
    beats[2] = 64'hBBBB_0000_0000_BBBB;
    beats[3] = 64'hCCCC_0000_0000_CCCC;
    pmem_read = 1'b1;
    pmem_address = 32'h0000_7000;
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      burst_rdata = beats[i];
      tick();
    end
    burst_resp = 1'b0;
    check("post_rst_resp", 256'(pmem_resp), 256'(1));
    check("post_rst_line", pmem_rdata256, mk_line(beats[3], beats[2], beats[1], beats[0]));
    pmem_read = 1'b0;
    tick();

    // ---- spurious burst_resp in IDLE, address/data changes mid-burst ----
    resp_mark = resp_cnt;
    burst_resp = 1'b1;
    tick();
    tick();
    check("spur_bread", 256'(burst_read), 256'(0));
    check("spur_bwrite", 256'(burst_write), 256'(0));
    check("spur_resp", 256'(pmem_resp), 256'(0));
    burst_resp = 1'b0;
    tick();
    check("spur_no_resp", 256'(resp_cnt - resp_mark), 256'(0));

    pmem_read = 1'b1;
    pmem_address = 32'h0000_8010;
    tick();
    pmem_address = 32'hFFFF_FFFF;
    beats[0] = 64'h0000_0000_0000_0001;
    beats[1] = 64'h0000_0000_0000_0002;
    beats[2] = 64'h0000_0000_0000_0003;
    beats[3] = 64'h0000_0000_0000_0004;
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      burst_rdata = beats[i];
      check("latch_baddr", 256'(burst_address), 256'(32'h0000_8000));
      tick();
      if (i == 1) begin
        burst_resp = 1'b0;
        check("gap_bread_hi", 256'(burst_read), 256'(1));
        tick();
      end
    end
    burst_resp = 1'b0;
    check("latch_line", pmem_rdata256, mk_line(beats[3], beats[2], beats[1], beats[0]));
    pmem_read = 1'b0;
    tick();

    wline = mk_line(64'h4, 64'h3, 64'h2, 64'h1);
    pmem_write = 1'b1;
    pmem_address = 32'h0000_9000;
    pmem_wdata256 = wline;
    tick();
    pmem_wdata256 = '1;
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      check("latch_wdata", 256'(burst_wdata), 256'(64'(i + 1)));
      tick();
    end
    burst_resp = 1'b0;
    check("latch_wline", pmem_rdata256, wline);
    pmem_write = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Responder for the data cache's physical-memory port (pmem_read / pmem_write / pmem_resp, 256-bit lines).
- Converts each line request into a 4-beat, 64-bit burst on the main-memory bus.
- Answers the cache with one pmem_resp pulse once the whole line has transferred.
- Sits between dcache and main memory or the arbiter.

Parameters:
LINE_W, 256, cache line width in bits
BEAT_W, 64, memory bus beat width in bits
BEATS, 4, beats per line; must equal LINE_W/BEAT_W
ADDR_W, 32, address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pmem_read  in  1  cache line-read request, level, held until pmem_resp
pmem_write  in  1  cache line-write request, level, held until pmem_resp
pmem_address  in  ADDR_W  line address from cache
pmem_wdata256  in  LINE_W  line to write back
pmem_rdata256  out  LINE_W  assembled read line, valid while pmem_resp=1
pmem_resp  out  1  one-cycle completion pulse to cache
burst_read  out  1  memory read request
burst_write  out  1  memory write request
burst_address  out  ADDR_W  line-aligned address, low log2(LINE_W/8) bits = 0
burst_wdata  out  BEAT_W  current write beat
burst_rdata  in  BEAT_W  returned read beat
burst_resp  in  1  beat handshake from memory, one pulse per beat

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat counter 0, line buffer 0, all outputs 0. Reset mid-burst abandons the transfer; no pmem_resp is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - pmem_write=1: latch pmem_wdata256 into the line buffer, latch aligned address, counter=0, go WR_BURST.
  - else pmem_read=1: latch aligned address, counter=0, go RD_BURST.
  - Both asserted: write wins.
  - burst_resp in IDLE is ignored.
- RD_BURST:
  - burst_read=1, burst_address=latched address.
  - Each cycle burst_resp=1: buffer[BEAT_W*cnt +: BEAT_W] <= burst_rdata, cnt++.
  - On the beat where cnt==BEATS-1: go DONE, counter clears.
  - Gaps between beats are tolerated; burst_read stays high until the last beat.
- WR_BURST:
  - burst_write=1, burst_wdata=buffer beat[cnt].
  - Each burst_resp advances cnt. On the last beat, go DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata256=line buffer. Write transfers return the written line.
  - Next state IDLE unconditionally. This gap guarantees the cache has dropped its request before IDLE resamples.
- Outputs: burst_read, burst_write and pmem_resp decode from registered state. burst_wdata comes from registers (no comb path from pmem_* to burst_*).
- Requests are latched: changes to pmem_address or pmem_wdata256 mid-transfer have no effect.
- Latency:
  - Request seen at edge 0 means burst_read/burst_write high from cycle 1.
  - Beats at cycles k..k+3 give pmem_resp in cycle k+4.
  - Minimum 6 cycles from request to resp with zero-wait memory.
- Counter width $clog2(BEATS); wraps to 0 on DONE entry, never beyond BEATS-1.
- Back-to-back: a cache writeback followed by a line fill gives WR_BURST, DONE, IDLE, RD_BURST with no lost request.

Decomposition:
- Shared package cache_pkg: state enum (IDLE, RD_BURST, WR_BURST, DONE), LINE_W/BEAT_W/BEATS constants, beat-index typedef.
- No sub-module required. The line buffer with its beat-indexed write port may optionally be split out as line_buffer for reuse in icache.

Test Plan:
- Read, zero wait: pmem_read=1, addr 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  -> burst_address=0x0000_1220.
  -> one pmem_resp pulse with rdata256 = {0x44..,0x33..,0x22..,0x11..}.
- Write, stalled: pmem_write=1, wdata256=0xDDDD..CCCC..BBBB..AAAA; burst_resp given with 2-cycle gaps.
  -> burst_wdata steps AAAA, BBBB, CCCC, DDDD, each held until its resp.
  -> burst_write high throughout; single pmem_resp after the 4th beat.
- Writeback then fill: pmem_write completes, then cache raises pmem_read one cycle later.
  -> two separate bursts; exactly two pmem_resp pulses; no beat crossover.
- Simultaneous pmem_read and pmem_write in IDLE -> write burst executes, burst_read stays 0.
- Reset after beat 2 of a read: rst_n low 1 cycle -> all outputs 0 immediately; no pmem_resp; next read starts cleanly at beat 0.
- Spurious burst_resp in IDLE, and pmem_address changed mid-burst -> no state change; burst_address stays at the latched value.
